// File: rtl/hydra_rd_sink_if.sv
// Read-lane handshake between one hydra output port and its packet sink.
interface hydra_rd_sink_if;
    logic        ready;
    logic        rd_sop;
    logic        rd_eop;
    logic        rd_vld;
    logic [15:0] rd_data;

    modport master (input ready, output rd_sop, rd_eop, rd_vld, rd_data);
    modport slave  (output ready, input rd_sop, rd_eop, rd_vld, rd_data);
endinterface

// File: rtl/hydra_rd_sink.sv
// Requests, parses and checks packets on one hydra read lane and keeps statistics.
// Payload sequence checking is compiled in only with `define HYDRA_RD_SINK_SEQCHK_EN.
module hydra_rd_sink #(
    parameter int unsigned PORT_ID = 0,
    parameter int unsigned GAP     = 0,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           enable,
    hydra_rd_sink_if.slave rd,
    output logic [15:0]    pkt_cnt,
    output logic [15:0]    err_cnt,
    output logic [4:0]     err_flags,
    output logic [1:0]     last_prio,
    output logic           busy
);

    localparam logic [1:0]  DEST_ID = 2'(PORT_ID);
    localparam logic [7:0]  GAP_CYC = 8'(GAP);
    localparam logic [15:0] TMO_CYC = 16'(TIMEOUT);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, HDR, PAY, GAPW} state_t;

    state_t      state, state_nx;
    logic [15:0] tmo_cnt, tmo_cnt_nx;
    logic [7:0]  gap_cnt, gap_cnt_nx;
    logic [8:0]  word_cnt, word_cnt_nx, word_cnt_inc;
    logic [8:0]  exp_len, exp_len_nx;
    logic        pkt_err, pkt_err_nx;
    logic        hdr_take, seq_bad, len_bad, dest_bad;
    logic        pkt_inc, err_inc;
    logic [4:0]  flags_set;
    logic        any_evt;
    logic        unused_rsvd;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [8:0] sat_inc9(input logic [8:0] v);
        return (v == 9'h1FF) ? v : v + 9'd1;
    endfunction

    // Header bits [15:12] are reserved and deliberately ignored.
    assign unused_rsvd  = ^rd.rd_data[15:12];
    assign any_evt      = rd.rd_sop | rd.rd_eop | rd.rd_vld;
    assign word_cnt_inc = rd.rd_vld ? sat_inc9(word_cnt) : word_cnt;
    assign len_bad      = (word_cnt_inc != exp_len);
    assign dest_bad     = (rd.rd_data[1:0] != DEST_ID);
    assign exp_len_nx   = hdr_take ? ({1'b0, rd.rd_data[11:4]} + 9'd1) : exp_len;

`ifdef HYDRA_RD_SINK_SEQCHK_EN
    logic [15:0] exp_word, exp_word_nx;

    assign seq_bad = (state == PAY) && !rd.rd_sop && rd.rd_vld && (rd.rd_data != exp_word);

    always_comb begin
        exp_word_nx = exp_word;
        if (hdr_take)
            exp_word_nx = 16'd1;
        else if ((state == PAY) && rd.rd_vld)
            exp_word_nx = exp_word + 16'd1;
    end

    always_ff @(posedge clk) begin
        exp_word <= exp_word_nx;
    end
`else
    assign seq_bad = 1'b0;
`endif

    always_comb begin
        state_nx    = state;
        tmo_cnt_nx  = tmo_cnt;
        gap_cnt_nx  = gap_cnt;
        word_cnt_nx = word_cnt;
        pkt_err_nx  = pkt_err;
        hdr_take    = 1'b0;
        pkt_inc     = 1'b0;
        err_inc     = 1'b0;
        flags_set   = '0;
        unique case (state)
            IDLE: begin
                flags_set[3] = any_evt;
                if (enable)
                    state_nx = REQ;
            end
            REQ: begin
                flags_set[3] = any_evt;
                tmo_cnt_nx   = '0;
                state_nx     = WAIT;
            end
            WAIT: begin
                if (rd.rd_sop) begin
                    flags_set[3] = rd.rd_eop;
                    pkt_err_nx   = 1'b0;
                    hdr_take     = rd.rd_vld;
                    state_nx     = HDR;
                end else begin
                    flags_set[3] = rd.rd_vld | rd.rd_eop;
                    if (tmo_cnt == TMO_CYC) begin
                        flags_set[4] = 1'b1;
                        err_inc      = 1'b1;
                        state_nx     = enable ? REQ : IDLE;
                    end else begin
                        tmo_cnt_nx = tmo_cnt + 16'd1;
                    end
                end
            end
            HDR: begin
                if (rd.rd_sop) begin
                    flags_set[3] = 1'b1;
                    err_inc      = 1'b1;
                    pkt_err_nx   = 1'b0;
                    hdr_take     = rd.rd_vld;
                end else if (rd.rd_eop) begin
                    flags_set[3] = 1'b1;
                    err_inc      = 1'b1;
                    gap_cnt_nx   = '0;
                    state_nx     = GAPW;
                end else begin
                    hdr_take = rd.rd_vld;
                end
            end
            PAY: begin
                if (rd.rd_sop) begin
                    flags_set[3] = 1'b1;
                    err_inc      = 1'b1;
                    pkt_err_nx   = 1'b0;
                    hdr_take     = rd.rd_vld;
                    state_nx     = HDR;
                end else begin
                    // A word arriving with rd_eop is counted before the length verdict.
                    word_cnt_nx  = word_cnt_inc;
                    flags_set[1] = seq_bad;
                    pkt_err_nx   = pkt_err | seq_bad;
                    if (rd.rd_eop) begin
                        flags_set[0] = len_bad;
                        if (pkt_err | seq_bad | len_bad)
                            err_inc = 1'b1;
                        else
                            pkt_inc = 1'b1;
                        gap_cnt_nx = '0;
                        state_nx   = GAPW;
                    end
                end
            end
            GAPW: begin
                flags_set[3] = any_evt;
                if (gap_cnt == GAP_CYC)
                    state_nx = enable ? REQ : IDLE;
                else
                    gap_cnt_nx = gap_cnt + 8'd1;
            end
            default: state_nx = IDLE;
        endcase
        if (hdr_take) begin
            state_nx     = PAY;
            word_cnt_nx  = '0;
            pkt_err_nx   = dest_bad;
            flags_set[2] = dest_bad;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rd.ready  <= 1'b0;
            busy      <= 1'b0;
            tmo_cnt   <= '0;
            gap_cnt   <= '0;
            word_cnt  <= '0;
            pkt_err   <= 1'b0;
            pkt_cnt   <= '0;
            err_cnt   <= '0;
            err_flags <= '0;
            last_prio <= '0;
        end else begin
            state     <= state_nx;
            rd.ready  <= (state_nx == REQ);
            busy      <= (state_nx != IDLE);
            tmo_cnt   <= tmo_cnt_nx;
            gap_cnt   <= gap_cnt_nx;
            word_cnt  <= word_cnt_nx;
            pkt_err   <= pkt_err_nx;
            err_flags <= err_flags | flags_set;
            if (pkt_inc)
                pkt_cnt <= sat_inc16(pkt_cnt);
            if (err_inc)
                err_cnt <= sat_inc16(err_cnt);
            if (hdr_take)
                last_prio <= rd.rd_data[3:2];
        end
    end

    always_ff @(posedge clk) begin
        exp_len <= exp_len_nx;
    end

endmodule

// File: tb/tb_hydra_rd_sink.sv
// Scoreboard bench for hydra_rd_sink: packet verdicts, gaps, timeout, abort, enable and reset.
module tb_hydra_rd_sink;
    localparam int TMO = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] pkt_cnt, err_cnt;
    logic [4:0]  err_flags;
    logic [1:0]  last_prio;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       good;
        logic [4:0] flags;
    } exp_t;

    typedef struct {
        logic [15:0] hdr;
        int          n;
        int          bad;
        bit          eop_last;
        bit          good;
        logic [4:0]  flags;
        logic [1:0]  prio;
    } vec_t;

    exp_t        sb[$];
    logic [15:0] m_pkt   = '0;
    logic [15:0] m_err   = '0;
    logic [4:0]  m_flags = '0;

    hydra_rd_sink_if rif();

    hydra_rd_sink #(.PORT_ID(0), .GAP(0), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .rd        (rif),
        .pkt_cnt   (pkt_cnt),
        .err_cnt   (err_cnt),
        .err_flags (err_flags),
        .last_prio (last_prio),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic idle_bus();
        rif.rd_sop  = 1'b0;
        rif.rd_eop  = 1'b0;
        rif.rd_vld  = 1'b0;
        rif.rd_data = '0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (rif.ready !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rif.ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_wait: ready=%b after %0d cycles, required 1", tag, rif.ready, n);
        end
    endtask

    task automatic pop_model();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow: scoreboard empty, required an entry");
        end else begin
            e = sb.pop_front();
            if (e.good) m_pkt = m_pkt + 16'd1;
            else        m_err = m_err + 16'd1;
            m_flags = m_flags | e.flags;
        end
    endtask

    // Called at a negedge with ready high; returns at the negedge after rd_eop was sampled.
    task automatic drive_pkt(input logic [15:0] hdr, input int n, input int bad,
                             input bit eop_last, input exp_t e);
        sb.push_back(e);
        @(negedge clk); rif.rd_sop = 1'b1;
        @(negedge clk); rif.rd_sop = 1'b0; rif.rd_vld = 1'b1; rif.rd_data = hdr;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            rif.rd_data = (k == bad) ? 16'h0000 : 16'(k + 1);
            rif.rd_eop  = eop_last && (k == n - 1);
        end
        if (!eop_last) begin
            @(negedge clk); rif.rd_vld = 1'b0; rif.rd_eop = 1'b1;
        end
        @(negedge clk); idle_bus();
    endtask

    task automatic test_reset();
        idle_bus();
        enable = 1'b0;
        rst    = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({rif.ready, busy, pkt_cnt, err_cnt, err_flags, last_prio} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b busy=%b pkt=%0d err=%0d flags=%b prio=%0d, required all 0",
                     rif.ready, busy, pkt_cnt, err_cnt, err_flags, last_prio);
        end
        rst    = 1'b0;
        enable = 1'b1;
        @(negedge clk);
        checks++;
        if (rif.ready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL first_request: ready=%b busy=%b, required 1 1", rif.ready, busy);
        end
    endtask

    task automatic test_packets();
        vec_t tbl[7];
        exp_t e;
        string tag;
        tbl[0] = '{16'h01F0, 32, -1, 1'b0, 1'b1, 5'b00000, 2'd0};
        tbl[1] = '{16'h01F0, 30, -1, 1'b0, 1'b0, 5'b00001, 2'd0};
        tbl[2] = '{16'h01F2, 32, -1, 1'b0, 1'b0, 5'b00100, 2'd0};
`ifdef HYDRA_RD_SINK_SEQCHK_EN
        tbl[3] = '{16'h01F0, 32,  5, 1'b0, 1'b0, 5'b00010, 2'd0};
`else
        tbl[3] = '{16'h01F0, 32,  5, 1'b0, 1'b1, 5'b00000, 2'd0};
`endif
        tbl[4] = '{16'h003C,  4, -1, 1'b1, 1'b1, 5'b00000, 2'd3};
        tbl[5] = '{16'hF004,  1, -1, 1'b1, 1'b1, 5'b00000, 2'd1};
        tbl[6] = '{16'h0008,  3, -1, 1'b0, 1'b0, 5'b00001, 2'd2};
        for (int i = 0; i < 7; i++) begin
            tag = $sformatf("pkt%0d", i);
            wait_ready(tag);
            e.good  = tbl[i].good;
            e.flags = tbl[i].flags;
            drive_pkt(tbl[i].hdr, tbl[i].n, tbl[i].bad, tbl[i].eop_last, e);
            pop_model();
            checks++;
            if (pkt_cnt !== m_pkt) begin
                errors++;
                $display("FAIL %s pkt_cnt: got %0d, required %0d", tag, pkt_cnt, m_pkt);
            end
            checks++;
            if (err_cnt !== m_err) begin
                errors++;
                $display("FAIL %s err_cnt: got %0d, required %0d", tag, err_cnt, m_err);
            end
            checks++;
            if (err_flags !== m_flags) begin
                errors++;
                $display("FAIL %s err_flags: got %b, required %b", tag, err_flags, m_flags);
            end
            checks++;
            if (last_prio !== tbl[i].prio) begin
                errors++;
                $display("FAIL %s last_prio: got %0d, required %0d", tag, last_prio, tbl[i].prio);
            end
            checks++;
            if (rif.ready !== 1'b0) begin
                errors++;
                $display("FAIL %s ready_eop1: got %b, required 0", tag, rif.ready);
            end
            @(negedge clk);
            checks++;
            if (rif.ready !== 1'b1) begin
                errors++;
                $display("FAIL %s ready_eop2: got %b, required 1", tag, rif.ready);
            end
        end
    endtask

    task automatic test_abort();
        exp_t e;
        wait_ready("abort");
        e.good = 1'b0; e.flags = 5'b01000; sb.push_back(e);
        @(negedge clk); rif.rd_sop = 1'b1;
        @(negedge clk); rif.rd_sop = 1'b0; rif.rd_vld = 1'b1; rif.rd_data = 16'h01F0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); rif.rd_data = 16'(k + 1);
        end
        @(negedge clk); rif.rd_vld = 1'b0; rif.rd_sop = 1'b1;
        @(negedge clk); rif.rd_sop = 1'b0; rif.rd_vld = 1'b1; rif.rd_data = 16'h01F0;
        pop_model();
        checks++;
        if (err_cnt !== m_err || err_flags !== m_flags) begin
            errors++;
            $display("FAIL abort_verdict: err=%0d flags=%b, required err=%0d flags=%b",
                     err_cnt, err_flags, m_err, m_flags);
        end
        e.good = 1'b1; e.flags = 5'b00000; sb.push_back(e);
        for (int k = 0; k < 32; k++) begin
            @(negedge clk); rif.rd_data = 16'(k + 1);
        end
        @(negedge clk); rif.rd_vld = 1'b0; rif.rd_eop = 1'b1;
        @(negedge clk); idle_bus();
        pop_model();
        checks++;
        if (pkt_cnt !== m_pkt || err_cnt !== m_err) begin
            errors++;
            $display("FAIL abort_restart: pkt=%0d err=%0d, required pkt=%0d err=%0d",
                     pkt_cnt, err_cnt, m_pkt, m_err);
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        int n;
        wait_ready("tmo");
        for (int r = 0; r < 2; r++) begin
            e.good = 1'b0; e.flags = 5'b10000; sb.push_back(e);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (rif.ready !== 1'b1 && n < 40);
            pop_model();
            checks++;
            if (n !== TMO + 2) begin
                errors++;
                $display("FAIL tmo%0d interval: got %0d cycles, required %0d", r, n, TMO + 2);
            end
            checks++;
            if (err_cnt !== m_err || err_flags !== m_flags) begin
                errors++;
                $display("FAIL tmo%0d stats: err=%0d flags=%b, required err=%0d flags=%b",
                         r, err_cnt, err_flags, m_err, m_flags);
            end
        end
    endtask

    task automatic test_enable_drop();
        exp_t e;
        int seen;
        wait_ready("en");
        e.good = 1'b1; e.flags = 5'b00000; sb.push_back(e);
        @(negedge clk); rif.rd_sop = 1'b1;
        @(negedge clk); rif.rd_sop = 1'b0; rif.rd_vld = 1'b1; rif.rd_data = 16'h0030;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); rif.rd_data = 16'(k + 1);
            if (k == 1) enable = 1'b0;
        end
        @(negedge clk); rif.rd_vld = 1'b0; rif.rd_eop = 1'b1;
        @(negedge clk); idle_bus();
        pop_model();
        checks++;
        if (pkt_cnt !== m_pkt || busy !== 1'b1) begin
            errors++;
            $display("FAIL en_complete: pkt=%0d busy=%b, required pkt=%0d busy=1", pkt_cnt, busy, m_pkt);
        end
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (rif.ready === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL en_parked: ready pulses=%0d busy=%b, required 0 0", seen, busy);
        end
        enable = 1'b1;
        @(negedge clk);
        checks++;
        if (rif.ready !== 1'b1) begin
            errors++;
            $display("FAIL en_resume: ready=%b, required 1", rif.ready);
        end
    endtask

    task automatic test_rst_mid();
        wait_ready("rst");
        @(negedge clk); rif.rd_sop = 1'b1;
        @(negedge clk); rif.rd_sop = 1'b0; rif.rd_vld = 1'b1; rif.rd_data = 16'h003C;
        @(negedge clk); rif.rd_data = 16'd1;
        @(negedge clk); rif.rd_data = 16'd2; rst = 1'b1;
        @(negedge clk); rif.rd_data = 16'd3; rst = 1'b0; enable = 1'b0;
        checks++;
        if ({rif.ready, busy, pkt_cnt, err_cnt, err_flags, last_prio} !== '0) begin
            errors++;
            $display("FAIL rst_mid_clear: ready=%b busy=%b pkt=%0d err=%0d flags=%b prio=%0d, required all 0",
                     rif.ready, busy, pkt_cnt, err_cnt, err_flags, last_prio);
        end
        sb.delete();
        m_pkt = '0; m_err = '0; m_flags = '0;
        @(negedge clk); rif.rd_data = 16'd4; rif.rd_eop = 1'b1;
        @(negedge clk); idle_bus();
        checks++;
        if (err_flags !== 5'b01000 || err_cnt !== 16'd0 || pkt_cnt !== 16'd0 || rif.ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_tail: flags=%b err=%0d pkt=%0d ready=%b, required 01000 0 0 0",
                     err_flags, err_cnt, pkt_cnt, rif.ready);
        end
    endtask

    initial begin
        test_reset();
        test_packets();
        test_abort();
        test_timeout();
        test_enable_drop();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hydra_rd_sink.md
# hydra_rd_sink

Read-side packet consumer for one hydra output port. It requests packets with a one-cycle `ready` pulse and receives the `rd_sop`/`rd_vld`/`rd_data`/`rd_eop` stream. It parses the 16-bit header word and checks payload length, destination and payload sequence. It keeps packet and error statistics. One instance sits on each of the four hydra read lanes, either as the synthesizable loopback sink in board bring-up or as the self-checking consumer in system simulation.

## Interface
Parameters:
- `PORT_ID`, 0: 2-bit port index this instance serves; compared with header `[1:0]`.
- `GAP`, 0: idle cycles between a sampled `rd_eop` and the next `ready` pulse (0..255).
- `TIMEOUT`, 1023: cycles to wait for `rd_sop` after `ready` before re-requesting (1..65535).

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  synchronous active-high reset.
- `enable`  in  1  allows new requests.
- `ready`  out  1  one-cycle request pulse to hydra.
- `rd_sop`  in  1  packet start pulse.
- `rd_eop`  in  1  packet end pulse.
- `rd_vld`  in  1  `rd_data` valid this cycle.
- `rd_data`  in  16  header word, then payload words.
- `pkt_cnt`  out  16  good packets; saturates at 16'hFFFF.
- `err_cnt`  out  16  bad packets, aborts and timeouts; saturates at 16'hFFFF.
- `err_flags`  out  5  sticky flags, cleared only by reset: [0] length, [1] sequence, [2] destination, [3] protocol, [4] timeout.
- `last_prio`  out  2  header `[3:2]` of the last accepted header.
- `busy`  out  1  high when the state is not IDLE.

## Operation
- Header word layout: `[15:12]` reserved (ignored); `[11:4]` L; `[3:2]` priority; `[1:0]` destination. The payload is L+1 words.
- Payload pattern: payload word k (k = 0..L) equals k+1, truncated to 16 bits.
- States:
  - IDLE: moves to REQ when `enable`=1.
  - REQ: pulses `ready` for one cycle, clears the timeout counter, moves to WAIT.
  - WAIT: on `rd_sop` moves to HDR. If the timeout counter reaches TIMEOUT, sets flag [4], increments `err_cnt` and returns to REQ.
  - HDR: the first `rd_vld` word is latched as the header. The header check sets flag [2] on destination mismatch and loads `last_prio`. The state then moves to PAY, with the word counter at 0 and the expected value at 1.
  - PAY: each `rd_vld` word increments the word counter (9 bits). When sequence checking is compiled in, a word not equal to the expected value sets flag [1]. On `rd_eop`, the state moves to GAPW.
  - GAPW: counts GAP cycles, then goes to REQ if `enable`=1, otherwise to IDLE.
- Verdict at `rd_eop`:
  - A word counter not equal to L+1 sets flag [0].
  - The packet is bad if any length, sequence or destination error arose within it (tracked by a per-packet error bit; `err_flags` themselves stay sticky). A bad packet increments `err_cnt`; otherwise `pkt_cnt` increments.
- `rd_eop` may arrive with the last `rd_vld` word, in which case that word is counted first, or on a later cycle.
- Protocol errors set flag [3]:
  - `rd_vld`, `rd_eop` or `rd_sop` in IDLE, REQ or GAPW: the event is ignored.
  - `rd_vld` or `rd_eop` in WAIT: the event is ignored.
  - `rd_eop` in HDR: `err_cnt` increments and the state moves to GAPW.
  - `rd_sop` in HDR or PAY: the current packet counts in `err_cnt` and the new packet restarts in HDR.
- Payload words beyond 511 saturate the word counter, so flag [0] is guaranteed.
- `enable` falling mid-packet: the current packet completes, then the block parks in IDLE.
- `rst` mid-packet: immediate return to IDLE and every output cleared. The remainder of the interrupted stream is treated as protocol violations.

## Timing
- Reset values: `ready`=0, `pkt_cnt`=0, `err_cnt`=0, `err_flags`=0, `last_prio`=0, `busy`=0.
- First request: `ready` is high in the 2nd cycle after `rst` deasserts with `enable`=1 (IDLE, then REQ registers the pulse).
- Between packets:
  - GAP=0: `ready` is high 2 cycles after the cycle `rd_eop` is sampled.
  - General case: `rd_eop` + 2 + GAP.
- `ready` is never high for two consecutive cycles.
- All outputs are registered. Counters and flags update in the cycle after the causing input is sampled.
- Timeout: `ready` re-pulses TIMEOUT+2 cycles after the previous pulse.

## Configuration
- Macro `HYDRA_RD_SINK_SEQCHK_EN`.
- Defined: payload compare logic is present and flag [1] is live.
- Undefined: the comparator and expected-value register are removed. Flag [1] is tied to 0, and only length, destination, protocol and timeout checks remain.

## Test plan
- Good packet: header 16'h01F0, `PORT_ID`=0, 32 payload words 1..32, `rd_eop` the cycle after the last word -> `pkt_cnt`=1, `err_flags`=0, `last_prio`=0, `ready` re-pulses 2 cycles after `rd_eop`.
- Short packet: header L=31 but 30 payload words -> `err_cnt`=1 and flag [0] set. Wrong destination (header 16'h01F2 at `PORT_ID`=0) -> flag [2] set and `err_cnt`=2.
- Sequence error: payload word 5 = 16'h0000 -> flag [1] with the macro defined; without the macro, `pkt_cnt` increments and flag [1] stays 0.
- Timeout: `TIMEOUT`=15, no `rd_sop` -> `ready` pulses every 17 cycles, flag [4] set, `err_cnt` increments per timeout.
- Abort and reset: `rd_sop` mid-payload -> flag [3] set, `err_cnt`+1, the new packet is accepted normally. `rst` asserted mid-packet -> all outputs 0 the next cycle.
- Saturation and enable: force 65536 good packets -> `pkt_cnt` holds 16'hFFFF. Drop `enable` mid-packet -> the packet completes, `busy`=0, no further `ready`.
